// File: rtl/mem_access_ctrl.sv
// Command sequencer in front of the 16x8 memory: single/burst read and write commands in, read beats out.
// Optional MEM_CTRL_CHECKSUM_EN adds rsp_sum, a running sum of the read beats of the current command.
module mem_access_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int FILL_INC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_last,
`ifdef MEM_CTRL_CHECKSUM_EN
    output logic [DATA_W-1:0] rsp_sum,
`endif
    output logic              busy,
    output logic              done
);

    // state    | meaning
    // IDLE     | waiting for a command, memory port parked in read
    // WR       | one write beat per cycle at mem_addr/mem_wdata
    // RD_ISSUE | read address presented, waiting for mem_rvalid
    // RSP      | read beat held on rsp_* until accepted
    // DONE     | one-cycle completion pulse
    typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RSP, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] len_q;

    assign cmd_ready = (state == IDLE);

    // mem_addr and mem_wdata double as the current burst address and fill value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            len_q     <= '0;
            mem_rw    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
            rsp_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef MEM_CTRL_CHECKSUM_EN
            rsp_sum   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    mem_rw <= 1'b1;
                    if (cmd_valid) begin
                        mem_addr  <= cmd_addr;
                        mem_wdata <= cmd_data;
                        cnt       <= '0;
                        len_q     <= cmd_op[1] ? cmd_len : '0;
                        busy      <= 1'b1;
`ifdef MEM_CTRL_CHECKSUM_EN
                        rsp_sum   <= '0;
`endif
                        if (!cmd_op[0]) begin
                            state  <= WR;
                            mem_rw <= 1'b0;
                        end else begin
                            state <= RD_ISSUE;
                        end
                    end
                end
                WR: begin
                    if (cnt == len_q) begin
                        state  <= DONE;
                        mem_rw <= 1'b1;
                        done   <= 1'b1;
                    end else begin
                        mem_addr  <= mem_addr + 1'b1;
                        mem_wdata <= mem_wdata + DATA_W'(FILL_INC);
                        cnt       <= cnt + 1'b1;
                    end
                end
                RD_ISSUE: begin
                    if (mem_rvalid) begin
                        rsp_data  <= mem_rdata;
                        rsp_addr  <= mem_addr;
                        rsp_last  <= (cnt == len_q);
                        rsp_valid <= 1'b1;
`ifdef MEM_CTRL_CHECKSUM_EN
                        rsp_sum   <= rsp_sum + mem_rdata;
`endif
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                            cnt      <= cnt + 1'b1;
                            state    <= RD_ISSUE;
                        end
                    end
                end
                DONE: begin
                    mem_rw <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural memory, reference memory image and directed + random commands.
module tb_mem_access_ctrl;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int FI = 1;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr, cmd_len;
    logic [DW-1:0] cmd_data;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_rvalid;
    logic          rsp_valid, rsp_ready, rsp_last, busy, done;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
`ifdef MEM_CTRL_CHECKSUM_EN
    logic [DW-1:0] rsp_sum;
`endif

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FILL_INC(FI)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .rsp_last(rsp_last),
`ifdef MEM_CTRL_CHECKSUM_EN
        .rsp_sum(rsp_sum),
`endif
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural 16x8 memory: write on the edge while rw=0, read data always presented.
    logic [DW-1:0] mem [DEPTH];
    logic          mem_clr = 1'b0;
    int            n_wr = 0;
    int            done_cnt = 0;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_rw === 1'b0) begin
            mem[mem_addr] <= mem_wdata;
            n_wr <= n_wr + 1;
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    logic [DW-1:0] ref_mem [DEPTH];
    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // rmode: 0 always ready, 1 random ready, 2 stall 5 cycles on beat 2. vmode: 0 rvalid=1, 1 random.
    task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [AW-1:0] len,
                          input logic [DW-1:0] data, input int rmode, input int vmode, input bit lat);
        int beats, nb, wr0, dn0, done_k, first_k, stall;
        bit is_rd, have_hold, rdy_seen;
        logic [AW-1:0] a, h_addr, h_maddr;
        logic [DW-1:0] h_data, exp_sum;
        logic [DW-1:0] exp_d[$];
        logic [AW-1:0] exp_a[$];
        beats = op[1] ? int'(len) + 1 : 1;
        is_rd = op[0];
        for (int i = 0; i < beats; i++) begin
            a = addr + AW'(i);
            if (is_rd) begin
                exp_a.push_back(a);
                exp_d.push_back(ref_mem[a]);
            end else begin
                ref_mem[a] = data + DW'(i * FI);
            end
        end
        rdy_seen = 1'b0;
        for (int w = 0; w < 50 && !rdy_seen; w++) begin
            @(negedge clk);
            rdy_seen = (cmd_ready === 1'b1);
        end
        chk("cmd_ready_before_cmd", {31'b0, rdy_seen}, 32'd1);
        wr0 = n_wr; dn0 = done_cnt;
        nb = 0; done_k = -1; first_k = -1; stall = 0; have_hold = 1'b0; exp_sum = '0;
        cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 300; k++) begin
            // keep a bogus command pending while busy; it must never be taken
            cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = AW'($urandom); cmd_data = DW'($urandom);
            mem_rvalid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (rmode == 0) rsp_ready = 1'b1;
            else if (rmode == 1) rsp_ready = $urandom_range(0, 1) != 0;
            else if (rsp_valid === 1'b1 && nb == 1 && stall < 5) begin rsp_ready = 1'b0; stall++; end
            else rsp_ready = 1'b1;
            @(negedge clk);
            chk("ready_vs_busy", {31'b0, cmd_ready}, {31'b0, !busy});
            if (is_rd) chk("rw_high_on_read", {31'b0, mem_rw}, 32'd1);
            if (rsp_valid === 1'b1) begin
                if (first_k < 0) first_k = k;
                if (have_hold) begin
                    chk("stall_data", {24'b0, rsp_data}, {24'b0, h_data});
                    chk("stall_addr", {28'b0, rsp_addr}, {28'b0, h_addr});
                    chk("stall_mem_addr", {28'b0, mem_addr}, {28'b0, h_maddr});
                end
                if (rsp_ready) begin
                    have_hold = 1'b0;
                    if (nb < beats && is_rd) begin
                        chk("beat_data", {24'b0, rsp_data}, {24'b0, exp_d[nb]});
                        chk("beat_addr", {28'b0, rsp_addr}, {28'b0, exp_a[nb]});
                        chk("beat_last", {31'b0, rsp_last}, {31'b0, nb == beats - 1});
`ifdef MEM_CTRL_CHECKSUM_EN
                        exp_sum = exp_sum + exp_d[nb];
                        chk("beat_sum", {24'b0, rsp_sum}, {24'b0, exp_sum});
`endif
                    end
                    nb++;
                end else begin
                    have_hold = 1'b1; h_data = rsp_data; h_addr = rsp_addr; h_maddr = mem_addr;
                end
            end
            if (done === 1'b1) begin
                done_k = k;
                cmd_valid = 1'b0;
                chk("ready_low_in_done", {31'b0, cmd_ready}, 32'd0);
                break;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (done_k < 0) chk("cmd_timeout", 32'd0, 32'd1);
        chk("beat_count", nb, is_rd ? beats : 0);
        chk("write_count", n_wr - wr0, is_rd ? 0 : beats);
        if (stall > 0) chk("stall_cycles", stall, 5);
        @(negedge clk);
        chk("done_single_pulse", done_cnt - dn0, 1);
        chk("done_low_after", {31'b0, done}, 32'd0);
        chk("ready_after_done", {31'b0, cmd_ready}, 32'd1);
        if (lat) begin
            if (is_rd) chk("read_latency", first_k, 1);
            else chk("write_latency", done_k, beats);
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0; cmd_data = '0;
        rsp_ready = 1'b1; mem_rvalid = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // asynchronous reset before the first clock edge
        rst_n = 1'b1;
        #1 rst_n = 1'b0; mem_clr = 1'b1;
        #2;
        chk("rst_mem_rw", {31'b0, mem_rw}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_mem_addr", {28'b0, mem_addr}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        mem_clr = 1'b0; rst_n = 1'b1;

        // single write then single read; len is ignored for singles
        do_cmd(2'b00, 4'd3, 4'd5, 8'hA5, 0, 0, 1);
        do_cmd(2'b01, 4'd3, 4'd9, 8'h00, 0, 0, 1);

        // wrapping fill and dump
        do_cmd(2'b10, 4'd14, 4'd3, 8'h10, 0, 0, 1);
        do_cmd(2'b11, 4'd14, 4'd3, 8'h00, 0, 0, 1);

        // backpressure on beat 2
        do_cmd(2'b11, 4'd14, 4'd3, 8'h00, 2, 0, 0);

        // reset while a beat is waiting on the response channel
        @(negedge clk);
        cmd_op = 2'b11; cmd_addr = 4'd14; cmd_len = 4'd3; cmd_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mid_rst_rsp_data", {24'b0, rsp_data}, 32'd0);
        chk("mid_rst_rsp_last", {31'b0, rsp_last}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_mem_addr", {28'b0, mem_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 1'b1;

        // reset after two beats of an 8-beat fill into a cleared memory
        @(negedge clk) mem_clr = 1'b1;
        @(negedge clk) mem_clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        begin
            int wr0;
            wr0 = n_wr;
            cmd_op = 2'b10; cmd_addr = 4'd0; cmd_len = 4'd7; cmd_data = 8'h40; cmd_valid = 1'b1;
            @(posedge clk); #1 cmd_valid = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("fill_rst_mem_rw", {31'b0, mem_rw}, 32'd1);
            chk("fill_rst_busy", {31'b0, busy}, 32'd0);
            chk("fill_rst_done", {31'b0, done}, 32'd0);
            chk("fill_rst_writes", n_wr - wr0, 2);
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("fill_rst_writes_later", n_wr - wr0, 2);
            rst_n = 1'b1;
        end
        ref_mem[0] = 8'h40; ref_mem[1] = 8'h41;
        do_cmd(2'b11, 4'd0, 4'd7, 8'h00, 1, 1, 0);

        // random commands with random backpressure and read latency
        for (int n = 0; n < 40; n++) begin
            do_cmd(2'($urandom), AW'($urandom), AW'($urandom), DW'($urandom), 1, 1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Command sequencer directly upstream of the 16x8 memory unit. Drives the memory's rw/addr/data_in port and consumes its data_out/data_valid.
- Accepts single and burst read/write commands over a valid/ready handshake.
- Returns read data on a valid/ready response channel with backpressure.
- Owns all memory port timing so that no spurious write can occur.

Parameters:
ADDR_W, 4, memory address width; depth is 2**ADDR_W.
DATA_W, 8, memory data width.
FILL_INC, 1, per-beat data increment for burst fill, applied mod 2**DATA_W.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  reset, asynchronous, active-low.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command; high only in IDLE.
cmd_op  in  2  00 single write, 01 single read, 10 burst fill, 11 burst dump.
cmd_addr  in  ADDR_W  start address.
cmd_len  in  ADDR_W  beats minus 1 for bursts; ignored for single ops (treated as 0).
cmd_data  in  DATA_W  write data, or first fill value.
mem_rw  out  1  to memory rw; 1 = read/idle, 0 = write.
mem_addr  out  ADDR_W  to memory addr.
mem_wdata  out  DATA_W  to memory data_in.
mem_rdata  in  DATA_W  from memory data_out.
mem_rvalid  in  1  from memory data_valid.
rsp_valid  out  1  read beat available.
rsp_ready  in  1  consumer accepts the beat.
rsp_data  out  DATA_W  read data.
rsp_addr  out  ADDR_W  address the beat was read from.
rsp_last  out  1  final beat of the command.
busy  out  1  high whenever state is not IDLE.
done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset values (asynchronous): state IDLE, mem_rw=1, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_last=0, busy=0, done=0, beat counter=0.
- Reset mid-command aborts immediately, with no further memory access. Memory contents already written remain.
- All outputs are registered except cmd_ready, which is decoded as state==IDLE.
- Command acceptance: on a clock edge with cmd_valid && cmd_ready, latch op, addr, len and data.
- States:
  - IDLE: mem_rw=1. On acceptance go to WR for ops 00/10, RD_ISSUE for ops 01/11.
  - WR: mem_rw=0, mem_addr=cur_addr, mem_wdata=cur_data; one beat per cycle. If cnt==len, go to DONE. Otherwise cur_addr+=1 (wraps mod 2**ADDR_W), cur_data+=FILL_INC (wraps mod 2**DATA_W), cnt+=1, stay in WR.
  - RD_ISSUE: mem_rw=1, mem_addr=cur_addr. When mem_rvalid=1 at the edge: rsp_data<=mem_rdata, rsp_addr<=cur_addr, rsp_last<=(cnt==len), rsp_valid<=1, go to RSP. If mem_rvalid=0, stay in RD_ISSUE.
  - RSP: rsp_valid, rsp_data, rsp_addr and rsp_last held stable; memory port unchanged. On rsp_ready: rsp_valid<=0. If rsp_last, go to DONE; otherwise cur_addr+=1 (wrap), cnt+=1, go to RD_ISSUE.
  - DONE: done=1 for exactly one cycle, mem_rw=1, then go to IDLE.
- mem_rw=0 only in WR. Leaving WR always restores mem_rw=1 on the next edge.
- Latency for a single write accepted at edge E0: write committed at E1, done high in cycle E1..E2, cmd_ready high after E2.
- Latency for a single read accepted at E0 with mem_rvalid=1: rsp_valid high from E1.
- Burst length is 1..2**ADDR_W beats. The address wraps 15→0 with no error.
- cmd_valid asserted while busy is ignored (not accepted). The upstream source holds it until cmd_ready.

Optional Feature:
MEM_CTRL_CHECKSUM_EN:
- Defined: adds output rsp_sum [DATA_W-1:0].
  - Cleared to 0 on command acceptance and on reset.
  - Updated to the mod-2**DATA_W running sum of all captured read beats of the current command, including the beat currently on rsp_data.
  - Valid whenever rsp_valid=1.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. Assert rst_n=0 mid-cycle, asynchronously → mem_rw=1, rsp_valid=0, busy=0, done=0, cmd_ready=1 after release.
2. Single write addr 3 data 0xA5, then single read addr 3 → rsp_data=0xA5, rsp_addr=3, rsp_last=1, done pulse once per command.
3. Fill addr 14, len 3, data 0x10 (FILL_INC=1), then dump addr 14, len 3 → beats (14,0x10), (15,0x11), (0,0x12), (1,0x13); rsp_last only on the 4th beat.
4. Dump with rsp_ready held low 5 cycles on beat 2 → rsp_data, rsp_addr and mem_addr stable; mem_rw=1 throughout; no beat lost or duplicated.
5. Reset asserted after 2 fill beats of a len-7 fill at addr 0 → writes stop at once, mem_rw=1. A subsequent dump shows addr 0..1 written and addr 2..7 equal to 0 (memory reset).
6. With MEM_CTRL_CHECKSUM_EN, repeat the dump of scenario 3 → rsp_sum=0x10, 0x21, 0x33, 0x46 on beats 1..4.
